load_store_unit: RTL and testbench

- Execution-stage load/store unit. Consumes the LSU enable, LSU uop, operands and rd address from the IS/EX pipeline register.
- Runs a request/valid handshake with data memory and produces an aligned, extended load result for the EX output mux and EX/WB register.
- Asserts busy_out so upstream stages stall while an access is in flight.

---
 rtl/load_store_unit.sv | 189 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Execution-stage load/store unit: computes the effective address, runs a
// request/valid handshake with data memory and returns an aligned, extended load result.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  enable_in,
  input  logic [3:0]            uop_in,
  input  logic [ADDR_WIDTH-1:0] base_in,
  input  logic [ADDR_WIDTH-1:0] offset_in,
  input  logic [DATA_WIDTH-1:0] store_data_in,
  input  logic [4:0]            rd_addr_in,
  output logic                  busy_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [DATA_WIDTH-1:0] mem_wdata_out,
  output logic [3:0]            mem_wstrb_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  input  logic                  mem_valid_in,
  input  logic [DATA_WIDTH-1:0] mem_rdata_in,
  output logic                  res_valid_out,
  output logic [DATA_WIDTH-1:0] res_data_out,
  output logic [4:0]            rd_addr_out,
  output logic                  rd_we_out,
  output logic                  exc_misaligned_out,
  output logic                  exc_illegal_out,
  output logic                  exc_bus_err_out
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [3:0]              uop_q;
  logic [1:0]              off_q;
  logic [4:0]              rd_q;
  logic                    busy_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [3:0]              mem_wstrb_q;
  logic                    mem_read_q;
  logic                    mem_write_q;
  logic                    res_valid_q;
  logic [DATA_WIDTH-1:0]   res_data_q;
  logic [4:0]              rd_addr_q;
  logic                    rd_we_q;
  logic                    exc_mis_q;
  logic                    exc_ill_q;
  logic                    exc_bus_q;

  logic [ADDR_WIDTH-1:0]   addr_d;
  logic                    illegal_d;
  logic                    misaligned_d;
  logic [DATA_WIDTH-1:0]   wdata_d;
  logic [3:0]              wstrb_d;
  logic [DATA_WIDTH-1:0]   rshift;
  logic [7:0]              rbyte;
  logic [15:0]             rhalf;
  logic [DATA_WIDTH-1:0]   load_d;

  always_comb begin
    addr_d       = base_in + offset_in;
    illegal_d    = (uop_in[1:0] == 2'b11);
    misaligned_d = ((uop_in[1:0] == 2'b01) && addr_d[0]) ||
                   ((uop_in[1:0] == 2'b10) && (addr_d[1:0] != 2'b00));
    wdata_d      = store_data_in;
    wstrb_d      = '0;
    case (uop_in[1:0])
      2'b00: begin
        wdata_d = {4{store_data_in[7:0]}};
        wstrb_d = 4'b0001 << addr_d[1:0];
      end
      2'b01: begin
        wdata_d = {2{store_data_in[15:0]}};
        wstrb_d = 4'b0011 << addr_d[1:0];
      end
      default: wstrb_d = '1;
    endcase
  end

  always_comb begin
    rshift = mem_rdata_in >> {off_q, 3'b000};
    rbyte  = rshift[7:0];
    rhalf  = off_q[1] ? mem_rdata_in[31:16] : mem_rdata_in[15:0];
    case (uop_q[1:0])
      2'b00:   load_d = uop_q[2] ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
      2'b01:   load_d = uop_q[2] ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
      default: load_d = mem_rdata_in;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      uop_q       <= '0;
      off_q       <= '0;
      rd_q        <= '0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      rd_addr_q   <= '0;
      rd_we_q     <= 1'b0;
      exc_mis_q   <= 1'b0;
      exc_ill_q   <= 1'b0;
      exc_bus_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_in) begin
            uop_q  <= uop_in;
            off_q  <= addr_d[1:0];
            rd_q   <= rd_addr_in;
            busy_q <= 1'b1;
            cnt_q  <= '0;
            if (illegal_d || misaligned_d) begin
              // Faulting ops complete directly without touching memory.
              state_q     <= DONE;
              res_valid_q <= 1'b1;
              res_data_q  <= '0;
              rd_we_q     <= 1'b0;
              rd_addr_q   <= rd_addr_in;
              exc_ill_q   <= illegal_d;
              exc_mis_q   <= misaligned_d && !illegal_d;
            end else begin
              state_q     <= REQ;
              mem_addr_q  <= {addr_d[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata_q <= wdata_d;
              mem_wstrb_q <= uop_in[3] ? wstrb_d : 4'b0000;
              mem_read_q  <= !uop_in[3];
              mem_write_q <= uop_in[3];
            end
          end
        end
        REQ: begin
          if (mem_valid_in || (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            // A valid response arriving on the final cycle still beats the timeout.
            state_q     <= DONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_wstrb_q <= '0;
            res_valid_q <= 1'b1;
            rd_addr_q   <= rd_q;
            exc_bus_q   <= !mem_valid_in;
            rd_we_q     <= mem_valid_in && !uop_q[3];
            res_data_q  <= (mem_valid_in && !uop_q[3]) ? load_d : '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
          rd_we_q     <= 1'b0;
          exc_mis_q   <= 1'b0;
          exc_ill_q   <= 1'b0;
          exc_bus_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_out           = busy_q;
  assign mem_addr_out       = mem_addr_q;
  assign mem_wdata_out      = mem_wdata_q;
  assign mem_wstrb_out      = mem_wstrb_q;
  assign mem_read_out       = mem_read_q;
  assign mem_write_out      = mem_write_q;
  assign res_valid_out      = res_valid_q;
  assign res_data_out       = res_data_q;
  assign rd_addr_out        = rd_addr_q;
  assign rd_we_out          = rd_we_q;
  assign exc_misaligned_out = exc_mis_q;
  assign exc_illegal_out    = exc_ill_q;
  assign exc_bus_err_out    = exc_bus_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and randomized ops checked each cycle
// against a transaction-level reference model.
module tb_load_store_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        enable_in;
  logic [3:0]  uop_in;
  logic [31:0] base_in, offset_in, store_data_in;
  logic [4:0]  rd_addr_in;
  logic        busy_out;
  logic [31:0] mem_addr_out, mem_wdata_out;
  logic [3:0]  mem_wstrb_out;
  logic        mem_read_out, mem_write_out;
  logic        mem_valid_in;
  logic [31:0] mem_rdata_in;
  logic        res_valid_out;
  logic [31:0] res_data_out;
  logic [4:0]  rd_addr_out;
  logic        rd_we_out;
  logic        exc_misaligned_out, exc_illegal_out, exc_bus_err_out;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock_in(clk), .reset_in(reset_in), .enable_in(enable_in), .uop_in(uop_in),
    .base_in(base_in), .offset_in(offset_in), .store_data_in(store_data_in),
    .rd_addr_in(rd_addr_in), .busy_out(busy_out), .mem_addr_out(mem_addr_out),
    .mem_wdata_out(mem_wdata_out), .mem_wstrb_out(mem_wstrb_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .mem_valid_in(mem_valid_in), .mem_rdata_in(mem_rdata_in),
    .res_valid_out(res_valid_out), .res_data_out(res_data_out),
    .rd_addr_out(rd_addr_out), .rd_we_out(rd_we_out),
    .exc_misaligned_out(exc_misaligned_out), .exc_illegal_out(exc_illegal_out),
    .exc_bus_err_out(exc_bus_err_out)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected outputs for the current cycle
  logic        chk_en = 1'b0, chk_req = 1'b0, chk_wdata = 1'b0;
  logic        exp_busy, exp_valid, exp_we, exp_mis, exp_ill, exp_bus, exp_read, exp_write;
  logic [31:0] exp_data, exp_addr, exp_wdata;
  logic [4:0]  exp_rd;
  logic [3:0]  exp_wstrb;
  logic [31:0] m_data = 0;
  logic [4:0]  m_rd = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model
  function automatic logic [31:0] load_val(input logic [3:0] u, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] v;
    case (u[1:0])
      2'b00: begin
        v = (rd >> (int'(a[1:0]) * 8)) & 32'hFF;
        if (!u[2] && v[7]) v = v | 32'hFFFFFF00;
      end
      2'b01: begin
        v = (rd >> (int'(a[1]) * 16)) & 32'hFFFF;
        if (!u[2] && v[15]) v = v | 32'hFFFF0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] wdata_of(input logic [3:0] u, input logic [31:0] d);
    case (u[1:0])
      2'b00:   return (d & 32'hFF) * 32'h01010101;
      2'b01:   return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] strb_of(input logic [3:0] u, input logic [31:0] a);
    case (u[1:0])
      2'b00:   return 4'(1 << a[1:0]);
      2'b01:   return 4'(3 << a[1:0]);
      default: return 4'hF;
    endcase
  endfunction

  // Single compare process
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy_out), 32'(exp_busy));
      chk("res_valid", 32'(res_valid_out), 32'(exp_valid));
      chk("res_data", res_data_out, exp_data);
      chk("rd_addr", 32'(rd_addr_out), 32'(exp_rd));
      chk("rd_we", 32'(rd_we_out), 32'(exp_we));
      chk("exc_mis", 32'(exc_misaligned_out), 32'(exp_mis));
      chk("exc_ill", 32'(exc_illegal_out), 32'(exp_ill));
      chk("exc_bus", 32'(exc_bus_err_out), 32'(exp_bus));
      chk("mem_read", 32'(mem_read_out), 32'(exp_read));
      chk("mem_write", 32'(mem_write_out), 32'(exp_write));
      if (chk_req) begin
        chk("mem_addr", mem_addr_out, exp_addr);
        chk("mem_wstrb", 32'(mem_wstrb_out), 32'(exp_wstrb));
        if (chk_wdata) chk("mem_wdata", mem_wdata_out, exp_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    exp_busy = 0; exp_valid = 0; exp_we = 0; exp_mis = 0; exp_ill = 0; exp_bus = 0;
    exp_read = 0; exp_write = 0; exp_data = m_data; exp_rd = m_rd;
    chk_req = 0; chk_wdata = 0;
  endtask

  // lat: REQ cycle in which mem_valid_in is driven (0 = never); rst_at: REQ cycle to reset in
  task automatic do_op(input logic [3:0] u, input logic [31:0] base, input logic [31:0] off,
                       input logic [31:0] sd, input logic [4:0] rd, input int lat,
                       input logic [31:0] rdata, input int rst_at, input bit jam);
    logic [31:0] a;
    bit ill, mis, bus;
    a = base + off;
    ill = (u[1:0] == 2'b11);
    mis = !ill && ((u[1:0] == 2'b01 && a[0]) || (u[1:0] == 2'b10 && a[1:0] != 2'b00));
    tick();
    enable_in = 1; uop_in = u; base_in = base; offset_in = off;
    store_data_in = sd; rd_addr_in = rd; mem_valid_in = 0;
    set_idle();
    tick();
    if (ill || mis) begin
      enable_in = 0;
      exp_busy = 1; exp_valid = 1; exp_ill = ill; exp_mis = mis;
      exp_data = 0; exp_we = 0; exp_rd = rd;
      m_data = 0; m_rd = rd;
      tick();
      set_idle();
      return;
    end
    for (int k = 1; k <= TIMEOUT; k++) begin
      if (jam) begin
        enable_in = 1; uop_in = 4'($urandom); base_in = $urandom; offset_in = $urandom;
        store_data_in = $urandom; rd_addr_in = 5'($urandom);
      end else begin
        enable_in = 0;
      end
      exp_busy = 1; exp_valid = 0; exp_we = 0; exp_mis = 0; exp_ill = 0; exp_bus = 0;
      exp_read = !u[3]; exp_write = u[3]; chk_req = 1;
      exp_addr = a & 32'hFFFF_FFFC;
      exp_wstrb = u[3] ? strb_of(u, a) : 4'h0;
      chk_wdata = u[3]; exp_wdata = wdata_of(u, sd);
      if (k == rst_at) begin
        reset_in = 1; enable_in = 0; mem_valid_in = 0;
        tick();
        m_data = 0; m_rd = 0;
        set_idle();
        chk_req = 1; chk_wdata = 1; exp_addr = 0; exp_wstrb = 0; exp_wdata = 0;
        reset_in = 0;
        tick();
        set_idle();
        return;
      end
      mem_valid_in = (k == lat);
      mem_rdata_in = (k == lat) ? rdata : $urandom;
      tick();
      if (k == lat) break;
    end
    enable_in = 0; mem_valid_in = 0;
    bus = (lat == 0 || lat > TIMEOUT);
    exp_busy = 1; exp_valid = 1; exp_read = 0; exp_write = 0; chk_req = 0; chk_wdata = 0;
    exp_bus = bus;
    exp_data = (bus || u[3]) ? 32'h0 : load_val(u, a, rdata);
    exp_we = !bus && !u[3];
    exp_rd = rd;
    m_data = exp_data; m_rd = rd;
    tick();
    set_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset_in = 1; enable_in = 0; uop_in = 0; base_in = 0; offset_in = 0;
    store_data_in = 0; rd_addr_in = 0; mem_valid_in = 0; mem_rdata_in = 0;
    set_idle();
    tick(); tick();
    chk_req = 1; chk_wdata = 1; exp_addr = 0; exp_wstrb = 0; exp_wdata = 0;
    chk_en = 1;
    tick();
    reset_in = 0;
    set_idle();

    // Pin the model to hand-computed values
    chk("pin_lb",  load_val(4'b0000, 32'h103, 32'h80112233), 32'hFFFFFF80);
    chk("pin_lbu", load_val(4'b0100, 32'h103, 32'h80112233), 32'h00000080);
    chk("pin_lh",  load_val(4'b0001, 32'h102, 32'h80112233), 32'hFFFF8011);
    chk("pin_sh_wdata", wdata_of(4'b1001, 32'h1234ABCD), 32'hABCDABCD);
    chk("pin_sh_wstrb", 32'(strb_of(4'b1001, 32'h202)), 32'h0000000C);

    // Directed ops
    do_op(4'b0010, 32'h100, 32'h4, 32'h0, 5'd7, 3, 32'hDEADBEEF, 0, 0);
    do_op(4'b0000, 32'h103, 32'h0, 32'h0, 5'd1, 1, 32'h80112233, 0, 0);
    do_op(4'b0100, 32'h103, 32'h0, 32'h0, 5'd2, 1, 32'h80112233, 0, 1);
    do_op(4'b0001, 32'h100, 32'h2, 32'h0, 5'd3, 2, 32'h80112233, 0, 0);
    do_op(4'b1001, 32'h202, 32'h0, 32'h1234ABCD, 5'd4, 2, 32'h0, 0, 0);
    do_op(4'b0010, 32'h102, 32'h0, 32'h0, 5'd9, 1, 32'h0, 0, 0);
    do_op(4'b0011, 32'h100, 32'h0, 32'h0, 5'd10, 1, 32'h0, 0, 0);
    do_op(4'b0010, 32'h300, 32'h0, 32'h0, 5'd11, 0, 32'h0, 0, 0);
    do_op(4'b0010, 32'h300, 32'h0, 32'h0, 5'd12, TIMEOUT, 32'h5A5A1234, 0, 0);
    do_op(4'b1010, 32'h300, 32'h0, 32'hCAFEF00D, 5'd13, 0, 32'h0, 0, 0);
    do_op(4'b0010, 32'h400, 32'h0, 32'h0, 5'd14, 0, 32'h0, 2, 0);
    do_op(4'b0010, 32'h400, 32'h8, 32'h0, 5'd15, 1, 32'h01234567, 0, 0);

    // Randomized ops
    for (int i = 0; i < 250; i++) begin
      int o;
      int lat;
      o = int'($urandom_range(0, 15)) - 8;
      lat = (i % 5 == 0) ? int'($urandom_range(0, 18)) : int'($urandom_range(1, 4));
      do_op(4'($urandom), $urandom, 32'(o), $urandom, 5'($urandom), lat, $urandom,
            (i % 37 == 5) ? int'($urandom_range(1, 3)) : 0, bit'($urandom_range(0, 1)));
    end

    tick();
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
